// File: rtl/win_pkg.sv
// Shared definitions for the window framer.
//   win_state_e : framer FSM state encoding (2 bits)
//   WIN_CNT_W   : width of the completed-window counter
//   clog2       : ceiling log2, used for derived counter widths
package win_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } win_state_e;

    localparam int WIN_CNT_W = 16;

    // clog2(1) = 0, clog2(2) = 1, clog2(8) = 3, clog2(9) = 4
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/win_out_stage.sv
// Single-entry valid/ready output register for the window framer.
// Carries one sample plus its {first, last, idx} sideband and holds all of it
// stable while o_valid is high and i_ready is low.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_load     : capture i_data/i_first/i_last/i_idx this cycle
//   i_ready    : downstream ready
//   o_free     : register can take a new sample this cycle
//   o_valid    : output sample valid
//   o_data, o_first, o_last, o_idx : registered sample and sideband
module win_out_stage #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_first,
    input  logic              i_last,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic              i_ready,
    output logic              o_free,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_first,
    output logic              o_last,
    output logic [IDX_W-1:0]  o_idx
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_first;
    logic              r_last;
    logic [IDX_W-1:0]  r_idx;

    // Empty, or the held sample leaves at this edge.
    assign o_free = ~r_valid | i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_idx   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_first <= i_first;
            r_last  <= i_last;
            r_idx   <= i_idx;
        end else if (i_ready) begin
            // Payload is left as-is; it is only meaningful while o_valid is high.
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_first = r_first;
    assign o_last  = r_last;
    assign o_idx   = r_idx;

endmodule

// File: rtl/win_framer.sv
// Window framer: slices a continuous sample stream into WIN_LEN-sample windows,
// tags each sample with first/last/index sideband, inserts GAP idle cycles
// between windows and abandons a partial window when en drops.
//   clk, rst_n          : clock, asynchronous active-low reset
//   en                  : framing enable (level)
//   s_valid/s_ready     : input sample handshake, s_data sample
//   m_valid/m_ready     : output sample handshake, m_data sample
//   win_first/win_last  : sample is first/last of its window (qualified by m_valid)
//   win_idx             : position of m_data within its window
//   win_cnt             : completed windows delivered downstream (wraps)
//   win_abort           : one-cycle pulse when a partial window is abandoned
//   o_dbg_state         : current FSM state
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. valid never depends on ready; once m_valid is high, m_data and sideband
// stay unchanged until m_ready accepts them. s_ready depends combinationally on
// m_ready only (plus registered state and the en level).
module win_framer import win_pkg::*; #(
    parameter int DATA_W  = 16,
    parameter int WIN_LEN = 8,
    parameter int GAP     = 2,
    parameter int IDX_W   = clog2(WIN_LEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_W-1:0]    s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_W-1:0]    m_data,
    output logic                 win_first,
    output logic                 win_last,
    output logic [IDX_W-1:0]     win_idx,
    output logic [WIN_CNT_W-1:0] win_cnt,
    output logic                 win_abort,
    output logic [1:0]           o_dbg_state
);

    localparam int GAP_W = (GAP > 1) ? clog2(GAP) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_END  = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    win_state_e           r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic [WIN_CNT_W-1:0] r_win_cnt;
    logic                 r_abort;

    logic w_slot_free;
    logic w_accept;
    logic w_deliver;
    logic w_first;
    logic w_last;

    assign s_ready   = (r_state == ST_RUN) & en & w_slot_free;
    assign w_accept  = s_valid & s_ready;
    assign w_deliver = m_valid & m_ready;
    assign w_first   = (r_idx == '0);
    assign w_last    = (r_idx == LAST_IDX);

    win_out_stage #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_data  (s_data),
        .i_first (w_first),
        .i_last  (w_last),
        .i_idx   (r_idx),
        .i_ready (m_ready),
        .o_free  (w_slot_free),
        .o_valid (m_valid),
        .o_data  (m_data),
        .o_first (win_first),
        .o_last  (win_last),
        .o_idx   (win_idx)
    );

    // Framing FSM with its index and gap counters. idx only moves on accept,
    // so backpressure freezes it; the gap counter ignores m_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_gap_cnt <= '0;
            r_abort   <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_idx     <= '0;
                    r_gap_cnt <= '0;
                    if (en) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        // A held output sample is not touched; it still drains.
                        r_state <= ST_IDLE;
                        r_idx   <= '0;
                        r_abort <= (r_idx != '0);
                    end else if (w_accept) begin
                        if (w_last) begin
                            r_idx     <= '0;
                            r_gap_cnt <= '0;
                            if (GAP > 0) begin
                                r_state <= ST_GAP;
                            end
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (!en) begin
                        r_state   <= ST_IDLE;
                        r_idx     <= '0;
                        r_gap_cnt <= '0;
                    end else if (r_gap_cnt == GAP_END) begin
                        r_state   <= ST_RUN;
                        r_gap_cnt <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Counts windows completed downstream, not upstream, so a window whose
    // last sample is still held does not count yet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt <= '0;
        end else if (w_deliver && win_last) begin
            r_win_cnt <= r_win_cnt + WIN_CNT_W'(1);
        end
    end

    assign win_cnt     = r_win_cnt;
    assign win_abort   = r_abort;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_win_framer.sv
// Directed bench for win_framer: u_dut0 uses WIN_LEN=8/GAP=2, u_dut1 uses
// WIN_LEN=8/GAP=0. A scoreboard tracks every u_dut0 delivery against the
// sample and sideband expected from its own window-position model.
module tb_win_framer;
    import win_pkg::*;

    localparam int WIN_LEN = 8;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- u_dut0 (GAP=2) ----------------
    logic        en, s_valid, s_ready, m_valid, m_ready;
    logic        win_first, win_last, win_abort;
    logic [15:0] s_data, m_data, win_cnt;
    logic [2:0]  win_idx;
    logic [1:0]  dbg_state;

    // ---------------- u_dut1 (GAP=0) ----------------
    logic        en1, s_valid1, s_ready1, m_valid1, m_ready1;
    logic        win_first1, win_last1, win_abort1;
    logic [15:0] s_data1, m_data1, win_cnt1;
    logic [2:0]  win_idx1;
    logic [1:0]  dbg_state1;

    win_framer #(.DATA_W(16), .WIN_LEN(WIN_LEN), .GAP(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .win_first(win_first), .win_last(win_last), .win_idx(win_idx),
        .win_cnt(win_cnt), .win_abort(win_abort), .o_dbg_state(dbg_state)
    );

    win_framer #(.DATA_W(16), .WIN_LEN(WIN_LEN), .GAP(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1),
        .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
        .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1),
        .win_first(win_first1), .win_last(win_last1), .win_idx(win_idx1),
        .win_cnt(win_cnt1), .win_abort(win_abort1), .o_dbg_state(dbg_state1)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_deliv  = 0;
    int m_idx    = 0;
    logic [20:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] outs0();
        return 64'({s_ready, m_valid, m_data, win_first, win_last, win_idx,
                    win_cnt, win_abort, dbg_state});
    endfunction

    // Scoreboard for u_dut0: push {data, first, last, idx} on accept, compare on delivery.
    always @(negedge clk) begin : mon
        logic [20:0] e;
        if (!rst_n) begin
            exp_q.delete();
            m_idx = 0;
        end else begin
            if (s_valid && s_ready) begin
                e = {s_data, (m_idx == 0), (m_idx == WIN_LEN - 1), 3'(m_idx)};
                exp_q.push_back(e);
                m_idx = (m_idx == WIN_LEN - 1) ? 0 : m_idx + 1;
            end
            if (!en) m_idx = 0;
            if (m_valid && m_ready) begin
                n_deliv++;
                if (exp_q.size() == 0) begin
                    chk("deliver_unexpected", 64'(m_data), 64'(exp_q.size()));
                end else begin
                    e = exp_q.pop_front();
                    chk("deliver", 64'({m_data, win_first, win_last, win_idx}), 64'(e));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer samples base, base+1, ... to u_dut0 until n are accepted (bounded).
    task automatic send_n(input int n, input int base);
        int got = 0;
        int cyc = 0;
        s_valid = 1'b1;
        s_data  = 16'(base);
        while (got < n && cyc < 50) begin
            @(negedge clk);
            if (s_valid && s_ready) got++;
            tick();
            s_data  = 16'(base + got);
            s_valid = (got < n);
            cyc++;
        end
        s_valid = 1'b0;
        chk("send_n_count", 64'(got), 64'(n));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    int d, k, ab, base;

    initial begin
        rst_n = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        en1 = 1'b0; s_valid1 = 1'b0; s_data1 = '0; m_ready1 = 1'b1;

        // ---- reset values, then RUN one cycle after release ----
        #12;
        @(negedge clk);
        chk("reset_outputs", outs0(), 64'(0));
        tick();
        rst_n = 1'b1; en = 1'b1; en1 = 1'b1;
        @(negedge clk);
        chk("idle_before_edge", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        chk("run_after_1cyc", 64'(dbg_state), 64'(ST_RUN));
        chk("s_ready_in_run", 64'(s_ready), 64'(1));

        // ---- 16 samples, GAP=2: s_ready low exactly 2 cycles after each last ----
        tick();
        d = 0; s_valid = 1'b1; s_data = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("gap2_s_ready_c%0d", c), 64'(s_ready), 64'(((c % 10) < 8) ? 1 : 0));
            if (s_valid && s_ready) d++;
            tick();
            s_data  = 16'(d);
            s_valid = (d < 16);
        end
        @(negedge clk);
        chk("win_cnt_two", 64'(win_cnt), 64'(2));
        chk("queue_drained_1", 64'(exp_q.size()), 64'(0));

        // ---- asynchronous reset mid-stream ----
        tick();
        s_valid = 1'b1; s_data = 16'h0100;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_valid", 64'(m_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", outs0(), 64'(0));
        s_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("run_after_midstream_reset", 64'(dbg_state), 64'(ST_RUN));

        // ---- backpressure at idx 3 ----
        base = n_deliv;
        send_n(4, 200);
        m_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_hold", 64'({m_valid, m_data, win_idx, s_ready}),
                64'({1'b1, 16'd203, 3'd3, 1'b0}));
        end
        tick();
        m_ready = 1'b1;
        send_n(4, 204);
        repeat (3) tick();
        chk("bp_win_cnt", 64'(win_cnt), 64'(1));
        chk("bp_deliveries", 64'(n_deliv - base), 64'(8));
        chk("queue_drained_2", 64'(exp_q.size()), 64'(0));

        // ---- abort after 5 samples with the 5th still held ----
        send_n(5, 300);
        en = 1'b0; m_ready = 1'b0;
        ab = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ab += int'(win_abort);
        end
        chk("abort_pulse_count", 64'(ab), 64'(1));
        chk("abort_held_sample", 64'({dbg_state, m_valid, m_data}),
            64'({ST_IDLE, 1'b1, 16'd304}));
        base = n_deliv;
        m_ready = 1'b1;
        tick();
        chk("abort_held_delivered", 64'({m_valid, 32'(n_deliv - base)}), 64'({1'b0, 32'd1}));
        en = 1'b1;
        send_n(1, 400);
        @(negedge clk);
        chk("restart_first", 64'({m_valid, m_data, win_first, win_last, win_idx}),
            64'({1'b1, 16'd400, 1'b1, 1'b0, 3'd0}));

        // ---- win_cnt wrap 0xFFFF -> 0 ----
        tick();
        force u_dut0.r_win_cnt = 16'hFFFF;
        tick();
        release u_dut0.r_win_cnt;
        @(negedge clk);
        chk("wrap_preload", 64'(win_cnt), 64'(16'hFFFF));
        send_n(7, 401);
        repeat (2) tick();
        @(negedge clk);
        chk("wrap_to_zero", 64'(win_cnt), 64'(0));

        // ---- GAP=0 instance: back-to-back windows, no bubble ----
        tick();
        s_valid1 = 1'b1; s_data1 = '0;
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            if (c < 16) chk($sformatf("gap0_s_ready_c%0d", c), 64'(s_ready1), 64'(1));
            if (c >= 1) begin
                k = (c - 1) % 8;
                chk($sformatf("gap0_out_c%0d", c),
                    64'({m_valid1, m_data1, win_first1, win_last1, win_idx1}),
                    64'({1'b1, 16'(c - 1), (k == 0), (k == 7), 3'(k)}));
            end
            tick();
            s_data1  = 16'(c + 1);
            s_valid1 = ((c + 1) < 16);
        end
        @(negedge clk);
        chk("gap0_win_cnt", 64'(win_cnt1), 64'(2));

        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
